shared_gate_arbiter: RTL and testbench

- Shares one logic-gate unit (NOT/AND/OR/XOR on WIDTH-bit operands) among N_REQ requesters.
- Round-robin arbitration; captures the winner's operands, executes, and returns a registered result tagged with the winner's index.
- Sits between the per-channel gate users and the single shared gate datapath; the only sequencer of that datapath.

---
 rtl/gate_arb_pkg.sv | 17 +
 rtl/gate_unit.sv | 30 +++
 rtl/shared_gate_arbiter.sv | 179 +++++++++++++++++
 tb/tb_shared_gate_arbiter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/gate_arb_pkg.sv
// Shared definitions for the shared gate arbiter.
// Contents:
//   OP_NOT/OP_AND/OP_OR/OP_XOR - 2-bit opcodes of the shared gate unit
//   state_e                    - arbiter FSM state encoding (ST_IDLE, ST_EXEC)
package gate_arb_pkg;

  localparam logic [1:0] OP_NOT = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_OR  = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_e;

endpackage

// File: rtl/gate_unit.sv
// Combinational bitwise gate datapath shared by all requesters.
// Ports:
//   op [1:0]       - opcode (NOT/AND/OR/XOR)
//   a  [WIDTH-1:0] - operand A
//   b  [WIDTH-1:0] - operand B (not used for NOT)
//   y  [WIDTH-1:0] - result
module gate_unit
  import gate_arb_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  // Opcode decode to bitwise result
  always_comb begin
    y = '0;
    case (op)
      OP_NOT:  y = ~a;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      default: y = ~a;
    endcase
  end

endmodule

// File: rtl/shared_gate_arbiter.sv
// Shares one gate unit among N_REQ requesters. Each grant takes two cycles:
// IDLE captures the winner's operands and pulses ack, EXEC registers the
// result with valid and the winner's index.
// Build option: ARB_FIXED_PRIO_EN selects fixed priority (lowest index wins,
// pointer held at 0); otherwise round-robin starting from the pointer.
// Ports:
//   clk, rst_n - clock (rising edge), asynchronous active-low reset
//   req        - per-requester level request
//   op_bus     - opcode of requester i at [2i+1:2i]
//   a_bus      - operand A of requester i at [WIDTH*i +: WIDTH]
//   b_bus      - operand B of requester i at [WIDTH*i +: WIDTH]
//   ack        - one-hot pulse, operands of requester i captured
//   y          - result, valid only while valid=1
//   valid      - one-cycle result strobe
//   id         - index of the requester owning y
//   busy       - high while in EXEC
module shared_gate_arbiter
  import gate_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [2*N_REQ-1:0]     op_bus,
  input  logic [WIDTH*N_REQ-1:0] a_bus,
  input  logic [WIDTH*N_REQ-1:0] b_bus,
  output logic [N_REQ-1:0]       ack,
  output logic [WIDTH-1:0]       y,
  output logic                   valid,
  output logic [ID_W-1:0]        id,
  output logic                   busy
);

  state_e           state_r, state_n;
  logic [ID_W-1:0]  ptr_r, ptr_n;
  logic [ID_W-1:0]  win_r, win_n;
  logic [ID_W-1:0]  id_r, id_n;
  logic [1:0]       op_r, op_n;
  logic [WIDTH-1:0] a_r, a_n, b_r, b_n, y_r, y_n;
  logic [N_REQ-1:0] ack_r, ack_n;
  logic             valid_r, valid_n, busy_r, busy_n;

  logic [N_REQ-1:0] rot_s;
  logic [ID_W-1:0]  off_s, win_s;
  logic [ID_W:0]    sum_s;
  logic             found_s;
  logic [N_REQ-1:0] grant_s;
  logic [1:0]       op_sel_s;
  logic [WIDTH-1:0] a_sel_s, b_sel_s, gate_y_s;

  // Winner search: rotate req so the pointer position lands at bit 0, take
  // the lowest set bit, then rotate the offset back into a requester index.
  always_comb begin
    rot_s   = N_REQ'({req, req} >> ptr_r);
    off_s   = '0;
    found_s = 1'b0;
    for (int j = 0; j < N_REQ; j++) begin
      if (!found_s && rot_s[j]) begin
        found_s = 1'b1;
        off_s   = ID_W'(j);
      end else begin
        found_s = found_s;
      end
    end
    sum_s = {1'b0, ptr_r} + {1'b0, off_s};
    if (sum_s >= (ID_W+1)'(N_REQ)) begin
      win_s = ID_W'(sum_s - (ID_W+1)'(N_REQ));
    end else begin
      win_s = sum_s[ID_W-1:0];
    end
    grant_s = {{(N_REQ-1){1'b0}}, 1'b1} << win_s;
  end

  // One-hot AND-OR mux of the winner's opcode and operands
  always_comb begin
    op_sel_s = 2'b00;
    a_sel_s  = '0;
    b_sel_s  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      op_sel_s = op_sel_s | (op_bus[2*i +: 2] & {2{grant_s[i]}});
      a_sel_s  = a_sel_s  | (a_bus[WIDTH*i +: WIDTH] & {WIDTH{grant_s[i]}});
      b_sel_s  = b_sel_s  | (b_bus[WIDTH*i +: WIDTH] & {WIDTH{grant_s[i]}});
    end
  end

  gate_unit #(.WIDTH(WIDTH)) u_gate (
    .op (op_r),
    .a  (a_r),
    .b  (b_r),
    .y  (gate_y_s)
  );

  // Next-state and next-output logic of the arbiter FSM
  always_comb begin
    state_n = state_r;
    ptr_n   = ptr_r;
    win_n   = win_r;
    id_n    = id_r;
    op_n    = op_r;
    a_n     = a_r;
    b_n     = b_r;
    y_n     = y_r;
    ack_n   = '0;
    valid_n = 1'b0;
    busy_n  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (found_s) begin
          win_n   = win_s;
          op_n    = op_sel_s;
          a_n     = a_sel_s;
          b_n     = b_sel_s;
          ack_n   = grant_s;
          busy_n  = 1'b1;
          state_n = ST_EXEC;
`ifdef ARB_FIXED_PRIO_EN
          ptr_n = '0;
`else
          if (win_s == ID_W'(N_REQ-1)) begin
            ptr_n = '0;
          end else begin
            ptr_n = win_s + ID_W'(1);
          end
`endif
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_EXEC: begin
        y_n     = gate_y_s;
        id_n    = win_r;
        valid_n = 1'b1;
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // State, pointer, latched operands and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      ptr_r   <= '0;
      win_r   <= '0;
      id_r    <= '0;
      op_r    <= 2'b00;
      a_r     <= '0;
      b_r     <= '0;
      y_r     <= '0;
      ack_r   <= '0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      ptr_r   <= ptr_n;
      win_r   <= win_n;
      id_r    <= id_n;
      op_r    <= op_n;
      a_r     <= a_n;
      b_r     <= b_n;
      y_r     <= y_n;
      ack_r   <= ack_n;
      valid_r <= valid_n;
      busy_r  <= busy_n;
    end
  end

  assign ack   = ack_r;
  assign y     = y_r;
  assign valid = valid_r;
  assign id    = id_r;
  assign busy  = busy_r;

endmodule

// File: tb/tb_shared_gate_arbiter.sv
// Directed-vector bench for shared_gate_arbiter (N_REQ=4, WIDTH=8).
module tb_shared_gate_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [7:0]  op_bus;
  logic [31:0] a_bus;
  logic [31:0] b_bus;
  logic [3:0]  ack;
  logic [7:0]  y;
  logic        valid;
  logic [1:0]  id;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  logic [1:0] op_tab  [3];
  logic [7:0] exp_tab [3];
  logic [3:0] fp_ack  [3];
  logic [1:0] fp_id   [3];
  logic [7:0] fp_y    [3];

  shared_gate_arbiter #(.N_REQ(4), .WIDTH(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .op_bus (op_bus),
    .a_bus  (a_bus),
    .b_bus  (b_bus),
    .ack    (ack),
    .y      (y),
    .valid  (valid),
    .id     (id),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_opnd(input int i, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    op_bus[2*i +: 2] = op;
    a_bus[8*i +: 8]  = a;
    b_bus[8*i +: 8]  = b;
  endtask

  task automatic expect_grant(input string tag, input logic [3:0] exp_ack);
    chk({tag, ".ack"},   32'(ack),   32'(exp_ack));
    chk({tag, ".busy"},  32'(busy),  32'h1);
    chk({tag, ".valid"}, 32'(valid), 32'h0);
  endtask

  task automatic expect_res(input string tag, input logic [1:0] exp_id, input logic [7:0] exp_y);
    chk({tag, ".valid"}, 32'(valid), 32'h1);
    chk({tag, ".id"},    32'(id),    32'(exp_id));
    chk({tag, ".y"},     32'(y),     32'(exp_y));
    chk({tag, ".ack"},   32'(ack),   32'h0);
    chk({tag, ".busy"},  32'(busy),  32'h0);
  endtask

  initial begin
    op_tab  = '{2'b01, 2'b10, 2'b11};
    exp_tab = '{8'h88, 8'hEE, 8'h66};
`ifdef ARB_FIXED_PRIO_EN
    fp_ack = '{4'b0001, 4'b0001, 4'b0001};
    fp_id  = '{2'd0, 2'd0, 2'd0};
    fp_y   = '{8'h33, 8'h33, 8'h33};
`else
    fp_ack = '{4'b0100, 4'b0001, 4'b0100};
    fp_id  = '{2'd2, 2'd0, 2'd2};
    fp_y   = '{8'h5A, 8'h33, 8'h5A};
`endif

    rst_n  = 1'b0;
    req    = 4'b0000;
    op_bus = 8'h00;
    a_bus  = 32'h0;
    b_bus  = 32'h0;

    // reset state
    step();
    chk("rst.ack",   32'(ack),   32'h0);
    chk("rst.y",     32'(y),     32'h0);
    chk("rst.valid", 32'(valid), 32'h0);
    chk("rst.id",    32'(id),    32'h0);
    chk("rst.busy",  32'(busy),  32'h0);
    step();
    rst_n = 1'b1;

    // round-robin: all four request, each drops after its own ack
    for (int i = 0; i < 4; i++) set_opnd(i, 2'b11, 8'hF0, 8'(i));
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      step();
      expect_grant("rr", 4'(1 << i));
      req[i] = 1'b0;
      step();
      expect_res("rr", 2'(i), 8'hF0 ^ 8'(i));
    end

    // pointer wrapped to 0
    req = 4'b1001;
    step();
    expect_grant("wrap", 4'b0001);
    req = 4'b0000;
    step();
    expect_res("wrap", 2'd0, 8'hF0);

    // single request, NOT
    set_opnd(1, 2'b00, 8'h0F, 8'h00);
    req = 4'b0010;
    step();
    expect_grant("single", 4'b0010);
    req = 4'b0000;
    step();
    expect_res("single", 2'd1, 8'hF0);
    step();
    chk("idle.valid", 32'(valid), 32'h0);
    chk("idle.ack",   32'(ack),   32'h0);
    chk("idle.y",     32'(y),     32'hF0);

    // AND / OR / XOR on requester 0
    for (int k = 0; k < 3; k++) begin
      set_opnd(0, op_tab[k], 8'hCC, 8'hAA);
      req = 4'b0001;
      step();
      expect_grant("opc", 4'b0001);
      req = 4'b0000;
      step();
      expect_res("opc", 2'd0, exp_tab[k]);
    end

    // requester 3 holds req for 6 cycles
    set_opnd(3, 2'b00, 8'h3C, 8'h00);
    req = 4'b1000;
    for (int k = 0; k < 3; k++) begin
      step();
      expect_grant("held", 4'b1000);
      step();
      expect_res("held", 2'd3, 8'hC3);
    end
    req = 4'b0000;
    step();
    chk("held.end.ack",   32'(ack),   32'h0);
    chk("held.end.valid", 32'(valid), 32'h0);

    // reset during EXEC
    set_opnd(2, 2'b01, 8'hFF, 8'h5A);
    req = 4'b0100;
    step();
    expect_grant("midrst", 4'b0100);
    rst_n = 1'b0;
    req   = 4'b0000;
    #1;
    chk("midrst.ack",   32'(ack),   32'h0);
    chk("midrst.y",     32'(y),     32'h0);
    chk("midrst.valid", 32'(valid), 32'h0);
    chk("midrst.id",    32'(id),    32'h0);
    chk("midrst.busy",  32'(busy),  32'h0);
    step();
    chk("midrst.hold.valid", 32'(valid), 32'h0);
    rst_n = 1'b1;

    // first grant after reset goes to requester 0, then contention 0 vs 2
    set_opnd(0, 2'b10, 8'h12, 8'h21);
    req = 4'b0101;
    step();
    expect_grant("post", 4'b0001);
    step();
    expect_res("post", 2'd0, 8'h33);
    for (int k = 0; k < 3; k++) begin
      step();
      expect_grant("prio", fp_ack[k]);
      step();
      expect_res("prio", fp_id[k], fp_y[k]);
    end
    req = 4'b0000;
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
